// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port 128x32 data SRAM.
// Port 0 (CPU) and port 1 (loader/debug) share the array. Arbitration is
// round-robin, except that port 1 may lock the bus. A lock is interrupted
// for one forced port-0 slot after LOCK_MAX consecutive locked grants.
// Grants and SRAM controls are combinational, so each access completes in
// its grant cycle. Read data comes back the following cycle to the port
// recorded in a one-entry read tag.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [6:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_stall,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [6:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_stall,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        CEN,
  output logic        WEN,
  output logic        OEN,
  output logic [6:0]  A,
  output logic [31:0] D,
  input  logic [31:0] Q
);

  localparam int unsigned       CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    ARB,
    LOCKED,
    FORCE0
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;      // port served most recently (1 = port 1)
  logic [CW-1:0] cnt_q, cnt_d;        // consecutive locked port-1 grants
  logic          tag_vld_q, tag_vld_d;
  logic          tag_port_q, tag_port_d;
  logic          gnt0, gnt1;

  // Arbitration: grant selection, FSM next state, RR pointer and lock count.
  // The FORCE0 decision looks at the count after this cycle's grant, so the
  // forced slot follows the LOCK_MAX-th locked grant with no idle cycle; a
  // saturated count forces on the first cycle port 0 asks.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    unique case (state_q)
      ARB: begin
        if (m0_req && (!m1_req || last_q)) begin
          gnt0 = 1'b1;
        end else if (m1_req) begin
          gnt1 = 1'b1;
        end
        if (gnt1 && m1_lock) begin
          state_d = LOCKED;
          cnt_d   = CW'(1);
        end
      end

      LOCKED: begin
        if (m1_req) begin
          gnt1 = 1'b1;
        end else if (m0_req) begin
          gnt0 = 1'b1;
        end
        if (!m1_req || !m1_lock) begin
          state_d = ARB;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
          if ((cnt_d == CNT_MAX) && m0_req) begin
            state_d = FORCE0;
          end
        end
      end

      FORCE0: begin
        gnt0 = m0_req;
        if (m1_req && m1_lock) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else begin
          state_d = ARB;
        end
      end

      default: begin
        state_d = ARB;
      end
    endcase

    // No SRAM access while reset is held, whatever the requests are doing.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      last_d = 1'b0;
    end
    if (gnt1) begin
      last_d = 1'b1;
    end
    // Leaving a lock always hands the next tie to port 0.
    if ((state_q == LOCKED) && (state_d == ARB)) begin
      last_d = 1'b1;
    end
  end

  // Read tag for next cycle: which port, if any, issued a read now.
  always_comb begin
    tag_vld_d  = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    tag_port_d = gnt1;
  end

  // State, pointer, counter and read tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  // SRAM request mux and per-port handshake outputs.
  always_comb begin
    m0_gnt   = gnt0;
    m1_gnt   = gnt1;
    m0_stall = m0_req && !gnt0;
    m1_stall = m1_req && !gnt1;
    CEN      = 1'b1;
    WEN      = 1'b1;
    OEN      = 1'b0;
    A        = '0;
    D        = '0;
    if (gnt0) begin
      CEN = 1'b0;
      WEN = !m0_we;
      A   = m0_addr;
      D   = m0_wdata;
    end else if (gnt1) begin
      CEN = 1'b0;
      WEN = !m1_we;
      A   = m1_addr;
      D   = m1_wdata;
    end
  end

  // Read return steering: only the tagged port sees Q.
  always_comb begin
    m0_rvalid = tag_vld_q && !tag_port_q;
    m1_rvalid = tag_vld_q && tag_port_q;
    m0_rdata  = m0_rvalid ? Q : '0;
    m1_rdata  = m1_rvalid ? Q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, multi-cycle lock/reset sequences
// and a randomized run, all checked against a behavioural model.
module tb_dmem_arbiter;

  localparam int unsigned LMAX = 16;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_stall, m0_rvalid;
  logic [6:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_stall, m1_rvalid;
  logic [6:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] D, Q;

  logic [31:0] sram [128];
  logic        mem_load;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic        m_locked, m_force, m_last, m_tv, m_tp;
  int unsigned m_run;
  logic [31:0] m_td;
  logic [31:0] ref_mem [128];

  dmem_arbiter #(.LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_stall(m1_stall), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM: write on WEN=0, registered read data otherwise.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) sram[i] <= 32'h1000_0000 + 32'(i);
    end else if (!CEN) begin
      if (!WEN) sram[A] <= D;
      else      Q <= sram[A];
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_force  = 1'b0;
    m_last   = 1'b1;
    m_run    = 0;
    m_tv     = 1'b0;
    m_tp     = 1'b0;
    m_td     = '0;
  endtask

  // Who gets the SRAM this cycle, from the arbitration rules.
  task automatic model_grant(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst_n) return;
    if (m_force) begin
      g0 = m0_req;
    end else if (m_locked) begin
      g1 = m1_req;
      g0 = m0_req && !m1_req;
    end else if (m0_req && m1_req) begin
      g0 = m_last;
      g1 = !m_last;
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
  endtask

  task automatic model_check();
    logic g0, g1;
    logic rv0, rv1;
    model_grant(g0, g1);
    rv0 = m_tv && !m_tp;
    rv1 = m_tv && m_tp;
    chk("model.gnt0", 32'(m0_gnt), 32'(g0));
    chk("model.gnt1", 32'(m1_gnt), 32'(g1));
    chk("model.stall0", 32'(m0_stall), 32'(m0_req && !g0));
    chk("model.stall1", 32'(m1_stall), 32'(m1_req && !g1));
    chk("model.CEN", 32'(CEN), 32'(!(g0 || g1)));
    chk("model.WEN", 32'(WEN), 32'(g0 ? !m0_we : (g1 ? !m1_we : 1'b1)));
    chk("model.OEN", 32'(OEN), 32'(0));
    chk("model.A", 32'(A), 32'(g0 ? m0_addr : (g1 ? m1_addr : 7'h0)));
    chk("model.D", D, g0 ? m0_wdata : (g1 ? m1_wdata : 32'h0));
    chk("model.rvalid0", 32'(m0_rvalid), 32'(rv0));
    chk("model.rvalid1", 32'(m1_rvalid), 32'(rv1));
    chk("model.rdata0", m0_rdata, rv0 ? m_td : 32'h0);
    chk("model.rdata1", m1_rdata, rv1 ? m_td : 32'h0);
  endtask

  // Advance the model across a rising edge using the inputs that were applied.
  task automatic model_update();
    logic g0, g1;
    model_grant(g0, g1);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tv = (g0 && !m0_we) || (g1 && !m1_we);
    m_tp = g1;
    if (g0) begin
      if (m0_we) ref_mem[m0_addr] = m0_wdata;
      else       m_td = ref_mem[m0_addr];
    end
    if (g1) begin
      if (m1_we) ref_mem[m1_addr] = m1_wdata;
      else       m_td = ref_mem[m1_addr];
    end
    if (m_force) begin
      m_force = 1'b0;
      if (g0) m_last = 1'b0;
      if (m1_req && m1_lock) begin
        m_locked = 1'b1;
        m_run    = 0;
      end else begin
        m_locked = 1'b0;
      end
    end else if (m_locked) begin
      m_last = 1'b1;
      if (!m1_req || !m1_lock) begin
        m_locked = 1'b0;
      end else begin
        if (m_run < LMAX) m_run++;
        if (m_run == LMAX && m0_req) m_force = 1'b1;
      end
    end else begin
      if (g0) m_last = 1'b0;
      if (g1) begin
        m_last = 1'b1;
        if (m1_lock) begin
          m_locked = 1'b1;
          m_run    = 1;
        end
      end
    end
  endtask

  task automatic step_begin();
    @(negedge clk);
    model_check();
  endtask

  task automatic step_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        r0, we0;
    logic [6:0]  a0;
    logic [31:0] wd0;
    logic        r1, we1;
    logic [6:0]  a1;
    logic [31:0] wd1;
    logic        lk1;
    logic        g0, g1, cen, wen;
    logic [6:0]  a;
    logic [31:0] d;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vt [16];

  initial begin
    int tie0, tie1, gr0, gr1;
    idle_inputs();
    rst_n    = 1'b0;
    mem_load = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    model_reset();
    @(posedge clk);
    #1 mem_load = 1'b0;

    // Inputs | expected gnt0 gnt1 CEN WEN A D | rvalid0 rvalid1 rdata0 rdata1
    vt[0]  = '{T,F,7'h05,32'h0,       T,F,7'h10,32'h0,    F, T,F,F,T,7'h05,32'h0,        F,F,32'h0,32'h0};
    vt[1]  = '{F,F,7'h00,32'h0,       T,F,7'h10,32'h0,    F, F,T,F,T,7'h10,32'h0,        T,F,32'h1000_0005,32'h0};
    vt[2]  = '{F,F,7'h00,32'h0,       F,F,7'h00,32'h0,    F, F,F,T,T,7'h00,32'h0,        F,T,32'h0,32'h1000_0010};
    vt[3]  = '{T,T,7'h7F,32'hDEADBEEF,F,F,7'h00,32'h0,    F, T,F,F,F,7'h7F,32'hDEADBEEF, F,F,32'h0,32'h0};
    vt[4]  = '{T,F,7'h7F,32'h0,       F,F,7'h00,32'h0,    F, T,F,F,T,7'h7F,32'h0,        F,F,32'h0,32'h0};
    vt[5]  = '{F,F,7'h00,32'h0,       F,F,7'h00,32'h0,    F, F,F,T,T,7'h00,32'h0,        T,F,32'hDEADBEEF,32'h0};
    vt[6]  = '{F,F,7'h00,32'h0,       T,F,7'h10,32'h0,    F, F,T,F,T,7'h10,32'h0,        F,F,32'h0,32'h0};
    vt[7]  = '{T,T,7'h20,32'h0A0A,    T,T,7'h21,32'h0B0B, F, T,F,F,F,7'h20,32'h0A0A,     F,T,32'h0,32'h1000_0010};
    for (int i = 8; i < 15; i++) begin
      vt[i] = vt[7];
      vt[i].rv1 = F;
      vt[i].rd1 = 32'h0;
      if (i % 2 == 0) begin
        vt[i].g0 = F; vt[i].g1 = T; vt[i].a = 7'h21; vt[i].d = 32'h0B0B;
      end
    end
    vt[15] = '{F,F,7'h00,32'h0,       F,F,7'h00,32'h0,    F, F,F,T,T,7'h00,32'h0,        F,F,32'h0,32'h0};

    // Reset state, then the directed table from a fresh reset.
    rst_n = 1'b0;
    #1;
    chk("reset.CEN", 32'(CEN), 32'(1));
    chk("reset.WEN", 32'(WEN), 32'(1));
    chk("reset.rvalid0", 32'(m0_rvalid), 32'(0));
    chk("reset.rvalid1", 32'(m1_rvalid), 32'(0));
    do_reset(2);

    tie0 = 0;
    tie1 = 0;
    for (int i = 0; i < 16; i++) begin
      m0_req = vt[i].r0; m0_we = vt[i].we0; m0_addr = vt[i].a0; m0_wdata = vt[i].wd0;
      m1_req = vt[i].r1; m1_we = vt[i].we1; m1_addr = vt[i].a1; m1_wdata = vt[i].wd1;
      m1_lock = vt[i].lk1;
      step_begin();
      chk($sformatf("vec%0d.gnt0", i), 32'(m0_gnt), 32'(vt[i].g0));
      chk($sformatf("vec%0d.gnt1", i), 32'(m1_gnt), 32'(vt[i].g1));
      chk($sformatf("vec%0d.stall0", i), 32'(m0_stall), 32'(vt[i].r0 && !vt[i].g0));
      chk($sformatf("vec%0d.stall1", i), 32'(m1_stall), 32'(vt[i].r1 && !vt[i].g1));
      chk($sformatf("vec%0d.CEN", i), 32'(CEN), 32'(vt[i].cen));
      chk($sformatf("vec%0d.WEN", i), 32'(WEN), 32'(vt[i].wen));
      chk($sformatf("vec%0d.A", i), 32'(A), 32'(vt[i].a));
      chk($sformatf("vec%0d.D", i), D, vt[i].d);
      chk($sformatf("vec%0d.rvalid0", i), 32'(m0_rvalid), 32'(vt[i].rv0));
      chk($sformatf("vec%0d.rvalid1", i), 32'(m1_rvalid), 32'(vt[i].rv1));
      chk($sformatf("vec%0d.rdata0", i), m0_rdata, vt[i].rd0);
      chk($sformatf("vec%0d.rdata1", i), m1_rdata, vt[i].rd1);
      if (i >= 7 && i <= 14) begin
        if (m0_gnt) tie0++;
        if (m1_gnt) tie1++;
      end
      step_end();
    end
    chk("tie.m0_grants", 32'(tie0), 32'(4));
    chk("tie.m1_grants", 32'(tie1), 32'(4));

    // Lock with m0 waiting: 16 m1 grants, one forced m0 grant, 4 more m1 grants.
    idle_inputs();
    do_reset(1);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 7'h40; m0_wdata = 32'h0000_4040;
    step_begin();
    step_end();
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 7'h41; m1_wdata = 32'h0;
    gr0 = 0;
    gr1 = 0;
    for (int c = 0; c < 40 && gr1 < 20; c++) begin
      m1_wdata = 32'(c);
      step_begin();
      chk($sformatf("lock%0d.gnt1", c), 32'(m1_gnt), 32'(c != 16));
      chk($sformatf("lock%0d.gnt0", c), 32'(m0_gnt), 32'(c == 16));
      chk($sformatf("lock%0d.stall0", c), 32'(m0_stall), 32'(c != 16));
      if (m1_gnt) gr1++;
      if (m0_gnt) gr0++;
      step_end();
    end
    chk("lock.m1_grants", 32'(gr1), 32'(20));
    chk("lock.m0_grants", 32'(gr0), 32'(1));
    m1_req = 1'b0;
    step_begin();
    chk("lock.exit_gnt0", 32'(m0_gnt), 32'(1));
    step_end();

    // Saturated lock count with m0 idle, then m0 arrives.
    idle_inputs();
    do_reset(1);
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 7'h50;
    repeat (20) begin
      step_begin();
      step_end();
    end
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 7'h51; m0_wdata = 32'h5151_5151;
    step_begin();
    chk("sat.gnt1", 32'(m1_gnt), 32'(1));
    chk("sat.gnt0", 32'(m0_gnt), 32'(0));
    step_end();
    step_begin();
    chk("sat.force_gnt0", 32'(m0_gnt), 32'(1));
    chk("sat.force_gnt1", 32'(m1_gnt), 32'(0));
    step_end();
    step_begin();
    chk("sat.relock_gnt1", 32'(m1_gnt), 32'(1));
    step_end();

    // Reset pulsed the cycle after a locked m1 read.
    idle_inputs();
    do_reset(1);
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 7'h33;
    step_begin();
    chk("rstlk.gnt1", 32'(m1_gnt), 32'(1));
    step_end();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstlk.rvalid1", 32'(m1_rvalid), 32'(0));
    chk("rstlk.gnt1_in_reset", 32'(m1_gnt), 32'(0));
    chk("rstlk.CEN_in_reset", 32'(CEN), 32'(1));
    do_reset(1);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'h34;
    step_begin();
    chk("rstlk.tie_gnt0", 32'(m0_gnt), 32'(1));
    chk("rstlk.tie_gnt1", 32'(m1_gnt), 32'(0));
    chk("rstlk.rvalid1_after", 32'(m1_rvalid), 32'(0));
    step_end();

    // Idle bus.
    idle_inputs();
    repeat (3) begin
      step_begin();
      chk("idle.CEN", 32'(CEN), 32'(1));
      step_end();
    end

    // Randomized traffic with a sticky lock and occasional resets.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
      m0_req   = ($urandom_range(0, 99) < 60);
      m0_we    = 1'($urandom_range(0, 1));
      m0_addr  = 7'($urandom);
      m0_wdata = $urandom;
      m1_req   = m1_lock ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 60);
      m1_we    = 1'($urandom_range(0, 1));
      m1_addr  = 7'($urandom);
      m1_wdata = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step_begin();
      step_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use clock clk, rising-edge; reset rst_n, asynchronous, active-low.
REQ-002 Parameter LOCK_MAX, default 16, is the maximum number of consecutive locked grants to port 1.
REQ-003 Ports SHALL be as follows:
  clk        in   1   clock
  rst_n      in   1   async active-low reset
  m0_req     in   1   port 0 (CPU) access request
  m0_we      in   1   port 0: 1 = write, 0 = read
  m0_addr    in   7   port 0 word address
  m0_wdata   in   32  port 0 write data
  m0_gnt     out  1   port 0 request accepted this cycle
  m0_stall   out  1   m0_req & ~m0_gnt
  m0_rvalid  out  1   port 0 read data valid
  m0_rdata   out  32  port 0 read data
  m1_req, m1_we, m1_addr[7], m1_wdata[32]  in   port 1 (loader/debug), same meanings
  m1_lock    in   1   port 1 requests bus lock
  m1_gnt, m1_stall, m1_rvalid, m1_rdata[32]  out  port 1, same meanings
  CEN        out  1   SRAM chip enable, active low
  WEN        out  1   SRAM write enable, 0 = write, 1 = read
  OEN        out  1   SRAM output enable, tied 0
  A          out  7   SRAM address
  D          out  32  SRAM write data
  Q          in   32  SRAM read data, valid one cycle after a read access

Function
REQ-004 At most one of m0_gnt and m1_gnt SHALL be 1 in any cycle; a grant is given only to a port whose req is 1.
REQ-005 Grant, CEN, WEN, A and D SHALL be combinational from the requests, FSM state, and RR pointer; the transfer completes in the grant cycle.
REQ-006 Granted port drives A = mX_addr, D = mX_wdata, WEN = ~mX_we, CEN = 0; with no grant, CEN = 1, WEN = 1, A = 0, D = 0.
REQ-007 The FSM SHALL have states ARB, LOCKED, and FORCE0.
REQ-008 ARB: if only one port requests, that port is granted; if both request, the port other than the RR pointer's last-served port is granted; pointer updates on every grant.
REQ-009 ARB -> LOCKED when m1 is granted with m1_lock = 1; the lock counter is loaded with 1.
REQ-010 LOCKED: m1 is granted whenever m1_req = 1, m0 is stalled, and each m1 grant increments the lock counter.
REQ-011 LOCKED -> ARB when m1_req = 0 or m1_lock = 0 (no grant that cycle to m1 if m1_req = 0; m0 may be granted); the pointer is set to port 1.
REQ-012 LOCKED -> FORCE0 when the counter reaches LOCK_MAX and m0_req = 1; FORCE0 grants m0 for exactly one cycle, then returns to LOCKED with the counter cleared if m1_lock and m1_req are still 1, else to ARB.
REQ-013 In FORCE0 with m0_req deasserted, no grant SHALL occur and the state returns as in REQ-012.
REQ-014 If the counter reaches LOCK_MAX with m0_req = 0, the block SHALL remain LOCKED and the counter saturates at LOCK_MAX.
REQ-015 Read response: a registered tag records {valid, port} for each granted read; the next cycle, the tagged port's rvalid = 1 and rdata = Q; the untagged port's rdata = 0.
REQ-016 Writes SHALL produce no rvalid.
REQ-017 Back-to-back reads from alternating ports SHALL each return on the following cycle with no bubbles.

Reset
REQ-018 While rst_n = 0, the state SHALL be ARB, the RR pointer = port 1 (so port 0 wins the first tie), the lock counter = 0, the read tag is invalid, both rvalid = 0, and CEN = 1, WEN = 1, and OEN = 0.
REQ-019 Reset asserted mid-lock or mid-read SHALL discard the pending rvalid and lock immediately; there is no rvalid in the first cycle after release.

Verification
REQ-020 Reset release, both ports read simultaneously (addr 0x05 / 0x10) -> m0 is granted first with A = 0x05; the next cycle, m1 is granted with A = 0x10, m0_rvalid = 1, and m0_rdata = Q.
REQ-021 m0 writes 0xDEADBEEF to 0x7F, then reads 0x7F -> CEN = 0, WEN = 0, D = 0xDEADBEEF; the next cycle, the read yields m0_rvalid = 1 and m0_rdata = 0xDEADBEEF.
REQ-022 m1 holds m1_lock = 1 for 20 consecutive requests while m0_req = 1 -> 16 m1 grants, 1 m0 grant (FORCE0), and then 4 m1 grants; m0_stall = 1 in all others.
REQ-023 Continuous requests from both ports without lock for 8 cycles -> grants alternate m0, m1, m0, ... with 4 grants each.
REQ-024 m1 is locked and reading, and rst_n is pulsed low on the cycle after the grant -> m1_rvalid stays 0, the state is ARB, and the next tie is granted to m0.
REQ-025 No requests -> CEN = 1, both gnt = 0, both rvalid = 0, and the state stays ARB.
